// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I sequencer.
// Holds the state enum, instruction classes, opcode constants and the
// datapath select encodings (alu_op values match the ALU decoder).
package multicycle_ctrl_pkg;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned CNT_W    = 32;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CL_R       = 4'd0,
    CL_IMM     = 4'd1,
    CL_LOAD    = 4'd2,
    CL_STORE   = 4'd3,
    CL_BRANCH  = 4'd4,
    CL_JAL     = 4'd5,
    CL_JALR    = 4'd6,
    CL_SYS     = 4'd7,
    CL_ILLEGAL = 4'd8
  } iclass_t;

  // RV32I major opcodes (IR[6:0])
  localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OP_SYSTEM = 7'b1110011;

  // alu_op
  localparam logic [SEL_W-1:0] ALU_ADD    = 2'b00;
  localparam logic [SEL_W-1:0] ALU_BRANCH = 2'b01;
  localparam logic [SEL_W-1:0] ALU_FUNCT  = 2'b10;

  // alu_src_a
  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

  // alu_src_b
  localparam logic [SEL_W-1:0] SRCB_RS2   = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;

  // wb_sel
  localparam logic [SEL_W-1:0] WB_ALUOUT  = 2'b00;
  localparam logic [SEL_W-1:0] WB_MDR     = 2'b01;
  localparam logic [SEL_W-1:0] WB_PC      = 2'b10;

  // pc_src and mem_addr_sel
  localparam logic PCSRC_ALU   = 1'b0;
  localparam logic PCSRC_ALUOUT = 1'b1;
  localparam logic ADDR_PC     = 1'b0;
  localparam logic ADDR_ALUOUT = 1'b1;

endpackage

// File: rtl/multicycle_ctrl_classify.sv
// insn_classify: combinational opcode-to-class map.
// Ports: i_opcode (IR[6:0]) in, o_class (instruction class) out.
module insn_classify
  import multicycle_ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] i_opcode,
  output iclass_t             o_class
);

  always_comb begin
    o_class = CL_ILLEGAL;
    case (i_opcode)
      OP_R:      o_class = CL_R;
      OP_IMM:    o_class = CL_IMM;
      OP_LOAD:   o_class = CL_LOAD;
      OP_STORE:  o_class = CL_STORE;
      OP_BRANCH: o_class = CL_BRANCH;
      OP_JAL:    o_class = CL_JAL;
      OP_JALR:   o_class = CL_JALR;
      OP_SYSTEM: o_class = CL_SYS;
      default:   o_class = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer for the RV32I
// multi-cycle core. Drives datapath selects and write enables, owns the
// memory request handshake, counts retired instructions and holds the
// sticky halted/illegal flags.
// Ports:
//   clk, reset (sync, active-high)
//   opcode, branch_taken, mem_ready                       - inputs
//   mem_req, mem_we, mem_addr_sel                         - memory port
//   ir_we, mdr_we, pc_we, pc_src, reg_we, wb_sel          - datapath enables
//   alu_src_a, alu_src_b, alu_op                          - ALU controls
//   instr_done, instret, halted, illegal                  - status
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                branch_taken,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_addr_sel,
  output logic                ir_we,
  output logic                mdr_we,
  output logic                pc_we,
  output logic                pc_src,
  output logic                reg_we,
  output logic [SEL_W-1:0]    wb_sel,
  output logic [SEL_W-1:0]    alu_src_a,
  output logic [SEL_W-1:0]    alu_src_b,
  output logic [SEL_W-1:0]    alu_op,
  output logic                instr_done,
  output logic [CNT_W-1:0]    instret,
  output logic                halted,
  output logic                illegal
);

  state_t           r_state;
  state_t           w_next;
  iclass_t          w_class;
  logic [CNT_W-1:0] r_instret;
  logic             r_halted;
  logic             r_illegal;
  logic             w_halt_set;
  logic             w_ill_set;

  insn_classify u_classify (
    .i_opcode (opcode),
    .o_class  (w_class)
  );

  // State register, retired counter and sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_FETCH;
      r_instret <= '0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (instr_done) begin
        r_instret <= r_instret + CNT_W'(1);
      end
      if (w_halt_set) begin
        r_halted <= 1'b1;
      end
      if (w_ill_set) begin
        r_illegal <= 1'b1;
      end
    end
  end

  // Next state and Mealy outputs; reset forces every strobe low that cycle
  always_comb begin
    w_next       = r_state;
    w_halt_set   = 1'b0;
    w_ill_set    = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = ADDR_PC;
    ir_we        = 1'b0;
    mdr_we       = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PCSRC_ALU;
    reg_we       = 1'b0;
    wb_sel       = WB_ALUOUT;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_RS2;
    alu_op       = ALU_ADD;
    instr_done   = 1'b0;

    if (!reset) begin
      case (r_state)
        ST_FETCH: begin
          mem_req      = 1'b1;
          mem_addr_sel = ADDR_PC;
          alu_src_a    = SRCA_PC;
          alu_src_b    = SRCB_FOUR;
          alu_op       = ALU_ADD;
          if (mem_ready) begin
            ir_we  = 1'b1;
            pc_we  = 1'b1;
            pc_src = PCSRC_ALU;
            w_next = ST_DECODE;
          end
        end

        // ALUOUT captures OLDPC+imm as the branch/JAL target
        ST_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          alu_op    = ALU_ADD;
          case (w_class)
            CL_SYS: begin
              w_next     = ST_HALT;
              w_halt_set = 1'b1;
            end
            CL_ILLEGAL: begin
              w_next     = ST_HALT;
              w_halt_set = 1'b1;
              w_ill_set  = 1'b1;
            end
            default: w_next = ST_EXEC;
          endcase
        end

        ST_EXEC: begin
          case (w_class)
            CL_R: begin
              alu_src_a = SRCA_RS1;
              alu_src_b = SRCB_RS2;
              alu_op    = ALU_FUNCT;
              w_next    = ST_WB;
            end
            CL_IMM: begin
              alu_src_a = SRCA_RS1;
              alu_src_b = SRCB_IMM;
              alu_op    = ALU_FUNCT;
              w_next    = ST_WB;
            end
            CL_LOAD, CL_STORE: begin
              alu_src_a = SRCA_RS1;
              alu_src_b = SRCB_IMM;
              alu_op    = ALU_ADD;
              w_next    = ST_MEM;
            end
            CL_BRANCH: begin
              alu_src_a  = SRCA_RS1;
              alu_src_b  = SRCB_RS2;
              alu_op     = ALU_BRANCH;
              pc_we      = branch_taken;
              pc_src     = PCSRC_ALUOUT;
              instr_done = 1'b1;
              w_next     = ST_FETCH;
            end
            CL_JAL: begin
              pc_we      = 1'b1;
              pc_src     = PCSRC_ALUOUT;
              reg_we     = 1'b1;
              wb_sel     = WB_PC;
              instr_done = 1'b1;
              w_next     = ST_FETCH;
            end
            CL_JALR: begin
              alu_src_a = SRCA_RS1;
              alu_src_b = SRCB_IMM;
              alu_op    = ALU_ADD;
              w_next    = ST_WB;
            end
            // Opcode changed under us after DECODE: park as illegal
            default: begin
              w_next     = ST_HALT;
              w_halt_set = 1'b1;
              w_ill_set  = 1'b1;
            end
          endcase
        end

        ST_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = ADDR_ALUOUT;
          mem_we       = (w_class == CL_STORE);
          if (mem_ready) begin
            if (w_class == CL_STORE) begin
              instr_done = 1'b1;
              w_next     = ST_FETCH;
            end else begin
              mdr_we = 1'b1;
              w_next = ST_WB;
            end
          end
        end

        ST_WB: begin
          reg_we     = 1'b1;
          instr_done = 1'b1;
          w_next     = ST_FETCH;
          case (w_class)
            CL_LOAD: wb_sel = WB_MDR;
            CL_JALR: begin
              wb_sel = WB_PC;
              pc_we  = 1'b1;
              pc_src = PCSRC_ALUOUT;
            end
            default: wb_sel = WB_ALUOUT;
          endcase
        end

        ST_HALT: w_next = ST_HALT;

        default: w_next = ST_FETCH;
      endcase
    end
  end

  assign instret = r_instret;
  assign halted  = r_halted;
  assign illegal = r_illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: table of instruction vectors with a
// scoreboard of expected per-instruction results, plus hand sequences for
// reset, halt, mid-wait reset and counter wrap.
module tb_multicycle_ctrl;

  logic        clk;
  logic        reset;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, pc_we, pc_src, reg_we;
  logic [1:0]  wb_sel, alu_src_a, alu_src_b, alu_op;
  logic        instr_done, halted, illegal;
  logic [31:0] instret;
  logic [18:0] outs;

  multicycle_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .mdr_we       (mdr_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .reg_we       (reg_we),
    .wb_sel       (wb_sel),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .instr_done   (instr_done),
    .instret      (instret),
    .halted       (halted),
    .illegal      (illegal)
  );

  assign outs = {mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, pc_we, pc_src, reg_we,
                 wb_sel, alu_src_a, alu_src_b, alu_op, instr_done, halted, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic       bt;
    int         fw;       // FETCH wait cycles
    int         mw;       // MEM wait cycles
    int         cyc;      // total cycles including done cycle
    logic       reg_we;   // values in the instr_done cycle
    logic [1:0] wb_sel;
    logic       pc_we;
    logic       pc_src;
    int         mdr_cnt;
    int         req_cyc;
    int         we_cyc;
  } vec_t;

  vec_t        vecs[12];
  vec_t        sb_q[$];
  int          checks;
  int          errors;
  logic [31:0] exp_instret;

  function automatic vec_t mk(input string nm, input logic [6:0] op, input logic bt,
                              input int fw, input int mw, input int cyc,
                              input logic rw, input logic [1:0] wb, input logic pw,
                              input logic ps, input int mdr, input int req, input int we);
    vec_t v;
    v.name = nm; v.op = op; v.bt = bt; v.fw = fw; v.mw = mw; v.cyc = cyc;
    v.reg_we = rw; v.wb_sel = wb; v.pc_we = pw; v.pc_src = ps;
    v.mdr_cnt = mdr; v.req_cyc = req; v.we_cyc = we;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Run one instruction from FETCH; responds to requests after the
  // vector's wait counts and glitches mem_ready when no request is up.
  task automatic run_insn(input vec_t v);
    int   cyc, req, we, mdr, irc, bad, phase, wcnt;
    bit   done;
    logic d_reg, d_pcwe, d_pcsrc;
    logic [1:0] d_wb;
    vec_t e;
    cyc = 0; req = 0; we = 0; mdr = 0; irc = 0; bad = 0; phase = 0; wcnt = 0;
    done = 0; d_reg = 0; d_pcwe = 0; d_pcsrc = 0; d_wb = 2'b00;
    sb_q.push_back(v);
    opcode = v.op;
    branch_taken = v.bt;
    while (!done && cyc < 60) begin
      @(negedge clk);
      if (mem_req) mem_ready = (wcnt == ((phase == 0) ? v.fw : v.mw));
      else         mem_ready = 1'($urandom_range(0, 1));
      #1;
      cyc++;
      if (mem_req) begin
        req++;
        if (mem_ready) begin phase++; wcnt = 0; end
        else wcnt++;
      end
      if (mem_we) we++;
      if (mdr_we) mdr++;
      if (ir_we)  irc++;
      if ((ir_we || mdr_we) && !mem_ready) bad++;
      if (instr_done) begin
        done = 1; d_reg = reg_we; d_wb = wb_sel; d_pcwe = pc_we; d_pcsrc = pc_src;
      end
    end
    if (!done) begin
      check({v.name, " timeout"}, 32'(done), 32'd1);
      void'(sb_q.pop_front());
      return;
    end
    e = sb_q.pop_front();
    check({e.name, " cycles"},    32'(cyc),     32'(e.cyc));
    check({e.name, " req_cyc"},   32'(req),     32'(e.req_cyc));
    check({e.name, " mem_we_cyc"}, 32'(we),     32'(e.we_cyc));
    check({e.name, " mdr_we_cnt"}, 32'(mdr),    32'(e.mdr_cnt));
    check({e.name, " ir_we_cnt"}, 32'(irc),     32'd1);
    check({e.name, " unready_we"}, 32'(bad),    32'd0);
    check({e.name, " reg_we"},    32'(d_reg),   32'(e.reg_we));
    check({e.name, " wb_sel"},    32'(d_wb),    32'(e.wb_sel));
    check({e.name, " pc_we"},     32'(d_pcwe),  32'(e.pc_we));
    check({e.name, " pc_src"},    32'(d_pcsrc), 32'(e.pc_src));
    @(posedge clk); #1;
    exp_instret = exp_instret + 32'd1;
    check({e.name, " instret"}, instret, exp_instret);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_instret = 32'd0;
  endtask

  // From FETCH, fetch op and step through DECODE into HALT
  task automatic enter_halt(input string nm, input logic [6:0] op, input logic exp_ill);
    int bad;
    logic [31:0] held;
    held = exp_instret;
    opcode = op;
    @(negedge clk); mem_ready = 1'b1; #1;
    @(negedge clk); mem_ready = 1'b0; #1;
    check({nm, " decode_sel"}, 32'({alu_src_a, alu_src_b, alu_op}), 32'b01_10_00);
    check({nm, " halted_in_decode"}, 32'(halted), 32'd0);
    @(negedge clk); #1;
    check({nm, " halted"},  32'(halted),  32'd1);
    check({nm, " illegal"}, 32'(illegal), 32'(exp_ill));
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      branch_taken = 1'($urandom_range(0, 1));
      #1;
      if (outs[18:2] != 17'd0) bad++;
    end
    check({nm, " halt_quiet_cycles"}, 32'(bad), 32'd0);
    check({nm, " halt_instret"}, instret, held);
    check({nm, " halted_sticky"}, 32'(halted), 32'd1);
  endtask

  initial begin
    checks = 0; errors = 0; exp_instret = 32'd0;
    reset = 1'b1; opcode = 7'd0; branch_taken = 1'b0; mem_ready = 1'b0;

    vecs[0]  = mk("R_add",     7'b0110011, 1'b0, 0, 0, 4, 1'b1, 2'b00, 1'b0, 1'b0, 0, 1, 0);
    vecs[1]  = mk("I_alu_w1",  7'b0010011, 1'b0, 1, 0, 5, 1'b1, 2'b00, 1'b0, 1'b0, 0, 2, 0);
    vecs[2]  = mk("load_w2_1", 7'b0000011, 1'b0, 2, 1, 8, 1'b1, 2'b01, 1'b0, 1'b0, 1, 5, 0);
    vecs[3]  = mk("load",      7'b0000011, 1'b0, 0, 0, 5, 1'b1, 2'b01, 1'b0, 1'b0, 1, 2, 0);
    vecs[4]  = mk("store",     7'b0100011, 1'b0, 0, 0, 4, 1'b0, 2'b00, 1'b0, 1'b0, 0, 2, 1);
    vecs[5]  = mk("store_w12", 7'b0100011, 1'b0, 1, 2, 7, 1'b0, 2'b00, 1'b0, 1'b0, 0, 5, 3);
    vecs[6]  = mk("br_taken",  7'b1100011, 1'b1, 0, 0, 3, 1'b0, 2'b00, 1'b1, 1'b1, 0, 1, 0);
    vecs[7]  = mk("br_not",    7'b1100011, 1'b0, 0, 0, 3, 1'b0, 2'b00, 1'b0, 1'b1, 0, 1, 0);
    vecs[8]  = mk("jal",       7'b1101111, 1'b0, 0, 0, 3, 1'b1, 2'b10, 1'b1, 1'b1, 0, 1, 0);
    vecs[9]  = mk("jalr",      7'b1100111, 1'b0, 0, 0, 4, 1'b1, 2'b10, 1'b1, 1'b1, 0, 1, 0);
    vecs[10] = mk("br_t_w3",   7'b1100011, 1'b1, 3, 0, 6, 1'b0, 2'b00, 1'b1, 1'b1, 0, 4, 0);
    vecs[11] = mk("jal_w1",    7'b1101111, 1'b0, 1, 0, 4, 1'b1, 2'b10, 1'b1, 1'b1, 0, 2, 0);

    // Reset state: handshake ignored while reset is high
    repeat (2) @(posedge clk);
    @(negedge clk); mem_ready = 1'b1; #1;
    check("reset_outs", 32'(outs), 32'd0);
    check("reset_instret", instret, 32'd0);
    reset = 1'b0; mem_ready = 1'b0; #1;
    check("fetch_req", 32'(mem_req), 32'd1);
    check("fetch_sel", 32'({mem_addr_sel, alu_src_a, alu_src_b, alu_op}), 32'b0_00_01_00);
    check("fetch_no_ir_we", 32'(ir_we), 32'd0);

    for (int i = 0; i < 12; i++) run_insn(vecs[i]);

    // Reset in the second cycle of a MEM wait
    opcode = 7'b0000011;
    @(negedge clk); mem_ready = 1'b1; #1;           // FETCH ready
    @(negedge clk); mem_ready = 1'b0; #1;           // DECODE
    @(negedge clk); #1;                             // EXEC
    check("load_exec_sel", 32'({alu_src_a, alu_src_b, alu_op}), 32'b10_10_00);
    @(negedge clk); #1;                             // MEM wait 1
    check("mem_wait_sel", 32'({mem_req, mem_addr_sel, mem_we}), 32'b110);
    @(negedge clk); reset = 1'b1; #1;               // MEM wait 2 with reset
    check("midwait_reset_outs", 32'(outs), 32'd0);
    @(negedge clk); reset = 1'b0; #1;
    check("post_reset_fetch", 32'({mem_req, mem_addr_sel}), 32'b10);
    check("post_reset_instret", instret, 32'd0);
    check("post_reset_flags", 32'({halted, illegal}), 32'd0);
    exp_instret = 32'd0;

    // Counter wrap from all-ones
    @(negedge clk);
    force dut.r_instret = 32'hFFFF_FFFF;
    #1;
    release dut.r_instret;
    exp_instret = 32'hFFFF_FFFF;
    run_insn(vecs[0]);
    run_insn(vecs[8]);

    // Illegal opcode, then ECALL after reset
    enter_halt("illegal", 7'b0000000, 1'b1);
    do_reset();
    #1;
    check("reset_clears_halt", 32'({halted, illegal}), 32'd0);
    enter_halt("ecall", 7'b1110011, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the bench can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
